// File: rtl/accum_dump_pkg.sv
// Shared types and constants for the accumulator dump controller.
// Holds the FSM encoding, the rounding constant and the signed saturation limits.
package accum_dump_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_ACCUM   = 2'd0;
  localparam state_t ST_DRAIN   = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;

  // Half an LSB of the shifted result, added before the arithmetic shift.
  function automatic longint round_const(input int unsigned shift);
    return 64'sd1 <<< (shift - 1);
  endfunction

  function automatic longint sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/accum_dump_fifo2.sv
// Two-entry synchronous FIFO with valid/ready on both sides.
// Accepts a push while full when a pop happens in the same cycle.
module accum_dump_fifo2 #(
  parameter int unsigned W = 21
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         push_c;
  logic         pop_c;

  assign full_o      = (count_q == 2'd2);
  assign empty_o     = (count_q == 2'd0);
  assign out_valid_o = ~empty_o;
  assign in_ready_o  = ~full_o | out_ready_i;
  assign push_c      = in_valid_i & in_ready_o;
  assign pop_c       = out_valid_o & out_ready_i;
  assign out_data_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_c) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/accum_dump_ctrl.sv
// Frame dump controller: counts samples, stalls the feeder while the accumulator drains,
// then rounds/saturates the captured sum into a 2-entry output buffer and clears the accumulator.
module accum_dump_ctrl
  import accum_dump_pkg::*;
#(
  parameter int unsigned ACC_W = 38,
  parameter int unsigned OUT_W = 20,
  parameter int unsigned SHIFT = 12,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid_i,
  output logic             in_ready_o,
  input  logic [CNT_W-1:0] dump_len_i,
  input  logic [ACC_W-1:0] acc_i,
  output logic             acc_clear_o,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_sat_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam int unsigned SW = ACC_W + 1;
  localparam logic signed [ACC_W:0] RND    = SW'(round_const(SHIFT));
  localparam logic signed [ACC_W:0] SAT_HI = SW'(sat_max(OUT_W));
  localparam logic signed [ACC_W:0] SAT_LO = SW'(sat_min(OUT_W));

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             in_ready_q;

  logic             accept_c;
  logic [CNT_W-1:0] len_in_c;
  logic [CNT_W-1:0] len_cur_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             push_c;

  logic signed [ACC_W:0] sum_c;
  logic signed [ACC_W:0] rnd_c;
  logic [OUT_W-1:0]      data_c;
  logic                  sat_c;

  logic             fifo_in_ready;
  logic             fifo_full;
  logic             fifo_empty;
  logic             unused_fifo_flags;
  logic [OUT_W:0]   fifo_head;

  assign accept_c  = sample_valid_i & in_ready_q;
  assign len_in_c  = (dump_len_i == '0) ? CNT_W'(1) : dump_len_i;
  assign len_cur_c = (cnt_q == '0) ? len_in_c : len_q;
  assign cnt_inc_c = cnt_q + CNT_W'(1);

  // Clearing the accumulator and pushing the word happen in the same CAPTURE cycle.
  assign acc_clear_o = (state_q == ST_CAPTURE) & fifo_in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    push_c  = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        if (accept_c) begin
          if (cnt_q == '0) len_d = len_in_c;
          if (cnt_inc_c == len_cur_c) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
      end
      ST_DRAIN: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        push_c = 1'b1;
        if (fifo_in_ready) state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ACCUM;
      cnt_q      <= '0;
      len_q      <= CNT_W'(1);
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      in_ready_q <= (state_d == ST_ACCUM);
    end
  end

  assign in_ready_o = in_ready_q;

  // Round half up, then clamp to the signed output range.
  assign sum_c = $signed({acc_i[ACC_W-1], acc_i}) + RND;
  assign rnd_c = sum_c >>> SHIFT;

  always_comb begin
    data_c = rnd_c[OUT_W-1:0];
    sat_c  = 1'b0;
    if (rnd_c > SAT_HI) begin
      data_c = SAT_HI[OUT_W-1:0];
      sat_c  = 1'b1;
    end else if (rnd_c < SAT_LO) begin
      data_c = SAT_LO[OUT_W-1:0];
      sat_c  = 1'b1;
    end
  end

  accum_dump_fifo2 #(.W(OUT_W + 1)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (push_c),
    .in_ready_o  (fifo_in_ready),
    .in_data_i   ({sat_c, data_c}),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign unused_fifo_flags = fifo_full ^ fifo_empty;
  assign out_sat_o  = fifo_head[OUT_W];
  assign out_data_o = fifo_head[OUT_W-1:0];

endmodule

// File: tb/tb_accum_dump_ctrl.sv
// Directed bench for accum_dump_ctrl with a behavioural 2-stage accumulator per DUT.
// DUT A uses SHIFT=4, DUT B uses SHIFT=1; both share the same stimulus.
module tb_accum_dump_ctrl;

  logic               clk;
  logic               reset;
  logic               sample_valid_i;
  logic               out_ready_i;
  logic [15:0]        dump_len_i;
  logic signed [37:0] sample;

  logic               in_ready_a, acc_clear_a, out_sat_a, out_valid_a;
  logic [19:0]        out_data_a;
  logic signed [37:0] i1_a, p_a, a_a;
  logic               in_ready_b, acc_clear_b, out_sat_b, out_valid_b;
  logic [19:0]        out_data_b;
  logic signed [37:0] i1_b, p_b, a_b;

  logic [19:0] qa_d[$];
  logic        qa_s[$];
  logic [19:0] qb_d[$];

  int tests;
  int fails;

  accum_dump_ctrl #(.ACC_W(38), .OUT_W(20), .SHIFT(4), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .sample_valid_i(sample_valid_i), .in_ready_o(in_ready_a),
    .dump_len_i(dump_len_i), .acc_i(p_a), .acc_clear_o(acc_clear_a), .out_data_o(out_data_a),
    .out_sat_o(out_sat_a), .out_valid_o(out_valid_a), .out_ready_i(out_ready_i)
  );

  accum_dump_ctrl #(.ACC_W(38), .OUT_W(20), .SHIFT(1), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .sample_valid_i(sample_valid_i), .in_ready_o(in_ready_b),
    .dump_len_i(dump_len_i), .acc_i(p_b), .acc_clear_o(acc_clear_b), .out_data_o(out_data_b),
    .out_sat_o(out_sat_b), .out_valid_o(out_valid_b), .out_ready_i(out_ready_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Accumulator: A registered into i1, then P += i1; the feeder drives A = 0 when stalled.
  assign a_a = (sample_valid_i && in_ready_a) ? sample : '0;
  assign a_b = (sample_valid_i && in_ready_b) ? sample : '0;

  always_ff @(posedge clk) begin
    if (reset || acc_clear_a) begin
      i1_a <= '0;
      p_a  <= '0;
    end else begin
      i1_a <= a_a;
      p_a  <= p_a + i1_a;
    end
    if (reset || acc_clear_b) begin
      i1_b <= '0;
      p_b  <= '0;
    end else begin
      i1_b <= a_b;
      p_b  <= p_b + i1_b;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid_a && out_ready_i) begin
        qa_d.push_back(out_data_a);
        qa_s.push_back(out_sat_a);
      end
      if (out_valid_b && out_ready_i) qb_d.push_back(out_data_b);
    end
  end

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_q();
    qa_d.delete();
    qa_s.delete();
    qb_d.delete();
  endtask

  task automatic feed(input logic signed [37:0] v);
    int g;
    g = 0;
    while (in_ready_a !== 1'b1 && g < 50) begin
      step();
      g++;
    end
    if (g >= 50) begin
      tests++; fails++;
      $display("FAIL feed_timeout: in_ready_o stuck at %b, required 1", in_ready_a);
    end
    sample_valid_i = 1'b1;
    sample         = v;
    step();
    sample_valid_i = 1'b0;
    sample         = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    tests++; if (in_ready_a !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b, required 0", in_ready_a); end
    tests++; if (out_valid_a !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, required 0", out_valid_a); end
    tests++; if (out_data_a !== 20'd0 || out_sat_a !== 1'b0) begin fails++; $display("FAIL reset_out_word: got %h/%b, required 0/0", out_data_a, out_sat_a); end
    tests++; if (acc_clear_a !== 1'b0) begin fails++; $display("FAIL reset_acc_clear: got %b, required 0", acc_clear_a); end
    reset = 1'b0;
    step();
    tests++; if (in_ready_a !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b, required 1", in_ready_a); end
  endtask

  task automatic test_basic_frame();
    int n;
    logic clr;
    logic signed [37:0] pcap;
    n = 0; clr = 1'b0; pcap = '0;
    dump_len_i = 16'd4;
    feed(38'sd100); feed(38'sd200); feed(-38'sd50); feed(38'sd30);
    while (in_ready_a === 1'b0 && n < 10) begin
      if (acc_clear_a === 1'b1) begin clr = 1'b1; pcap = p_a; end
      n++;
      step();
    end
    tests++; if (n != 2) begin fails++; $display("FAIL basic_gap: in_ready_o low %0d cycles, required 2", n); end
    tests++; if (clr !== 1'b1 || pcap !== 38'sd280) begin fails++; $display("FAIL basic_capture: clear %b P %0d, required 1 and 280", clr, pcap); end
    tests++; if (out_valid_a !== 1'b1 || out_data_a !== 20'd18 || out_sat_a !== 1'b0) begin
      fails++; $display("FAIL basic_word: valid %b data %0d sat %b, required 1 18 0", out_valid_a, $signed(out_data_a), out_sat_a);
    end
    tests++; if (p_a !== 38'sd0) begin fails++; $display("FAIL basic_cleared: P %0d, required 0", p_a); end
    step(2);
  endtask

  task automatic test_rounding();
    clear_q();
    dump_len_i = 16'd1;
    feed(-38'sd24); feed(-38'sd8); feed(38'sd8);
    step(6);
    tests++;
    if (qa_d.size() != 3) begin
      fails++; $display("FAIL round_count: got %0d words, required 3", qa_d.size());
    end else begin
      if (qa_d[0] !== 20'hFFFFF || qa_d[1] !== 20'd0 || qa_d[2] !== 20'd1) begin
        fails++; $display("FAIL round_values: got %0d %0d %0d, required -1 0 1", $signed(qa_d[0]), $signed(qa_d[1]), $signed(qa_d[2]));
      end
      tests++; if (qa_s[0] !== 1'b0 || qa_s[1] !== 1'b0 || qa_s[2] !== 1'b0) begin fails++; $display("FAIL round_sat: got %b%b%b, required 000", qa_s[0], qa_s[1], qa_s[2]); end
    end
    tests++; if (qb_d.size() < 1 || qb_d[0] !== 20'hFFFF4) begin fails++; $display("FAIL round_shift1: got size %0d, required first word -12", qb_d.size()); end
  endtask

  task automatic test_saturation();
    clear_q();
    dump_len_i = 16'd1;
    feed(38'sh40000000); feed(-38'sh40000000); feed(38'sd8388592); feed(38'sd8388600);
    step(6);
    tests++;
    if (qa_d.size() != 4) begin
      fails++; $display("FAIL sat_count: got %0d words, required 4", qa_d.size());
    end else begin
      if (qa_d[0] !== 20'h7FFFF || qa_s[0] !== 1'b1) begin fails++; $display("FAIL sat_pos: got %0d/%b, required 524287/1", $signed(qa_d[0]), qa_s[0]); end
      tests++; if (qa_d[1] !== 20'h80000 || qa_s[1] !== 1'b1) begin fails++; $display("FAIL sat_neg: got %0d/%b, required -524288/1", $signed(qa_d[1]), qa_s[1]); end
      tests++; if (qa_d[2] !== 20'h7FFFF || qa_s[2] !== 1'b0) begin fails++; $display("FAIL sat_edge_in: got %0d/%b, required 524287/0", $signed(qa_d[2]), qa_s[2]); end
      tests++; if (qa_d[3] !== 20'h7FFFF || qa_s[3] !== 1'b1) begin fails++; $display("FAIL sat_edge_over: got %0d/%b, required 524287/1", $signed(qa_d[3]), qa_s[3]); end
    end
  endtask

  task automatic test_backpressure();
    clear_q();
    out_ready_i = 1'b0;
    dump_len_i  = 16'd2;
    feed(38'sd16); feed(38'sd16); feed(38'sd32); feed(38'sd32); feed(38'sd48); feed(38'sd48);
    step(6);
    tests++; if (in_ready_a !== 1'b0 || acc_clear_a !== 1'b0) begin fails++; $display("FAIL bp_hold: in_ready %b clear %b, required 0 0", in_ready_a, acc_clear_a); end
    tests++; if (out_valid_a !== 1'b1 || out_data_a !== 20'd2) begin fails++; $display("FAIL bp_head: valid %b data %0d, required 1 2", out_valid_a, out_data_a); end
    tests++; if (p_a !== 38'sd96 || qa_d.size() != 0) begin fails++; $display("FAIL bp_stable: P %0d pops %0d, required 96 0", p_a, qa_d.size()); end
    out_ready_i = 1'b1;
    #1;
    tests++; if (acc_clear_a !== 1'b1) begin fails++; $display("FAIL bp_pop_push: clear %b, required 1", acc_clear_a); end
    step();
    tests++; if (in_ready_a !== 1'b1 || out_data_a !== 20'd4) begin fails++; $display("FAIL bp_resume: in_ready %b head %0d, required 1 4", in_ready_a, out_data_a); end
    step(6);
    tests++;
    if (qa_d.size() != 3 || qa_d[0] !== 20'd2 || qa_d[1] !== 20'd4 || qa_d[2] !== 20'd6) begin
      fails++; $display("FAIL bp_order: got %0d words, required 2 4 6 in order", qa_d.size());
    end
  endtask

  task automatic test_len_zero();
    int n;
    clear_q();
    out_ready_i = 1'b1;
    dump_len_i  = 16'd0;
    for (int i = 1; i <= 3; i++) begin
      feed(38'(16 * i));
      n = 0;
      while (in_ready_a === 1'b0 && n < 10) begin
        n++;
        step();
      end
      tests++; if (n != 2) begin fails++; $display("FAIL len0_gap%0d: in_ready_o low %0d cycles, required 2", i, n); end
    end
    step(2);
    tests++;
    if (qa_d.size() != 3 || qa_d[0] !== 20'd1 || qa_d[1] !== 20'd2 || qa_d[2] !== 20'd3) begin
      fails++; $display("FAIL len0_words: got %0d words, required 1 2 3", qa_d.size());
    end
  endtask

  task automatic test_len_change();
    clear_q();
    dump_len_i = 16'd3;
    feed(38'sd16);
    dump_len_i = 16'd5;
    feed(38'sd16); feed(38'sd16);
    tests++; if (in_ready_a !== 1'b0) begin fails++; $display("FAIL lenchg_end3: in_ready %b, required 0", in_ready_a); end
    step(5);
    tests++; if (qa_d.size() != 1 || qa_d[0] !== 20'd3) begin fails++; $display("FAIL lenchg_word3: got %0d words, required one word of 3", qa_d.size()); end
    for (int i = 0; i < 4; i++) feed(38'sd16);
    tests++; if (in_ready_a !== 1'b1) begin fails++; $display("FAIL lenchg_mid5: in_ready %b, required 1", in_ready_a); end
    feed(38'sd16);
    tests++; if (in_ready_a !== 1'b0) begin fails++; $display("FAIL lenchg_end5: in_ready %b, required 0", in_ready_a); end
    step(5);
    tests++; if (qa_d.size() != 2 || qa_d[1] !== 20'd5) begin fails++; $display("FAIL lenchg_word5: got %0d words, required second word 5", qa_d.size()); end
  endtask

  task automatic test_reset_mid_frame();
    out_ready_i = 1'b0;
    dump_len_i  = 16'd1;
    feed(38'sd7);
    dump_len_i  = 16'd4;
    feed(38'sd1); feed(38'sd1);
    reset = 1'b1;
    step();
    tests++; if (out_valid_b !== 1'b0 || out_data_b !== 20'd0) begin fails++; $display("FAIL rstmid_out: valid %b data %0d, required 0 0", out_valid_b, out_data_b); end
    tests++; if (in_ready_b !== 1'b0 || acc_clear_b !== 1'b0) begin fails++; $display("FAIL rstmid_ctrl: in_ready %b clear %b, required 0 0", in_ready_b, acc_clear_b); end
    step();
    reset = 1'b0;
    out_ready_i = 1'b1;
    clear_q();
    for (int i = 0; i < 4; i++) feed(38'sd1);
    step(5);
    tests++; if (qb_d.size() != 1 || qb_d[0] !== 20'd2) begin fails++; $display("FAIL rstmid_word: got %0d words, required one word of 2", qb_d.size()); end
    tests++; if (qa_d.size() != 1 || qa_d[0] !== 20'd0) begin fails++; $display("FAIL rstmid_word_a: got %0d words, required one word of 0", qa_d.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    sample_valid_i = 1'b0;
    sample = '0;
    out_ready_i = 1'b1;
    dump_len_i = 16'd4;
    test_reset();
    test_basic_frame();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_len_zero();
    test_len_change();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/accum_dump_ctrl.md
# accum_dump_ctrl

Dump controller for the 38-bit signed accumulator. Counts accepted input samples, stalls the sample feeder at frame end while the accumulator pipeline drains, and captures the final sum. It then rounds and saturates the sum to an output word and clears the accumulator. Rounded results leave through a 2-entry valid/ready buffer toward the downstream consumer.

## Interface
- ACC_W, 38, accumulator width (matches accumulator P)
- OUT_W, 20, output word width
- SHIFT, 12, right-shift applied before saturation (1 ≤ SHIFT < ACC_W)
- CNT_W, 16, width of frame-length counter
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- sample_valid_i  in  1  feeder presents a sample (A) this cycle
- in_ready_o  out  1  feeder may present samples; when low the feeder drives A = 0
- dump_len_i  in  CNT_W  samples per frame; 0 treated as 1
- acc_i  in  ACC_W  accumulator output P (signed)
- acc_clear_o  out  1  drives accumulator reset; clears i1 and P on the next edge
- out_data_o  out  OUT_W  rounded, saturated frame sum (signed)
- out_sat_o  out  1  saturation occurred for out_data_o
- out_valid_o  out  1  output word available
- out_ready_i  in  1  consumer accepts word when out_valid_o & out_ready_i

## Operation
- States: ACCUM, DRAIN, CAPTURE.
- ACCUM: in_ready_o = 1. An accepted sample is sample_valid_i & in_ready_o. dump_len_i is latched into len_q when cnt = 0 and a sample is accepted. The sample that brings cnt to len_q (or the first sample if dump_len_i = 0) sets cnt to 0 and moves to DRAIN.
- DRAIN: exactly 1 cycle, in_ready_o = 0, then CAPTURE.
- CAPTURE: in_ready_o = 0.
  - If the buffer has space (or a pop occurs this cycle), push the rounded word, assert acc_clear_o, and move to ACCUM.
  - Otherwise hold in CAPTURE with acc_clear_o = 0. acc_i stays stable because the feeder drives A = 0.
- Rounding: s = sext(acc_i, ACC_W+1) + 2^(SHIFT-1); r = s >>> SHIFT (arithmetic).
- Saturation:
  - r > 2^(OUT_W-1)-1 → 2^(OUT_W-1)-1, sat = 1.
  - r < -2^(OUT_W-1) → -2^(OUT_W-1), sat = 1.
  - Otherwise sat = 0.
- Buffer: 2 entries, each OUT_W+1 bits. A push and a pop in the same cycle on a full buffer are both legal. Pop order is FIFO.
- acc_clear_o is combinational from state and buffer status, with no combinational path from sample_valid_i.

## Timing
- A sample accepted in cycle t reaches P at the end of cycle t+1. DRAIN covers t+1, and CAPTURE samples acc_i in t+2.
- Dump gap: in_ready_o is low for at least 2 cycles per frame. ACCUM resumes in t+3 when there is no backpressure.
- Capture-to-output latency: out_valid_o rises 1 cycle after the CAPTURE push when the buffer was empty.
- Reset values: in_ready_o 0 during reset and 1 after, acc_clear_o 0, out_valid_o 0, out_data_o 0, out_sat_o 0, state ACCUM, cnt 0, buffer empty.
- Reset mid-frame discards the partial count and any buffered words. The accumulator is cleared by the system reset separately.
- len_q is frozen for the whole frame. Changes to dump_len_i mid-frame take effect on the next frame.
- Out-of-frame cycles (sample_valid_i = 0 in ACCUM) do not advance cnt.

## Structure
- Package accum_dump_pkg: state enum (ST_ACCUM, ST_DRAIN, ST_CAPTURE), rounding-constant function, saturation limits derived from OUT_W.
- Sub-module accum_dump_fifo2: 2-entry synchronous FIFO with valid/ready on both sides and full/empty outputs, width parameter.
- Top: FSM, sample counter, round/saturate datapath, accumulator instance wiring in the integration bench only.

## Test plan
- SHIFT=4, dump_len=4, samples 100, 200, -50, 30 (add) → P=280, out_data_o=18, out_sat_o=0; in_ready_o low exactly 2 cycles; P=0 after the clear.
- SHIFT=4, one frame with P=-24 → (-24+8)>>>4 = -1; with P=-8 → 0; with P=8 → 1 (round-half-up checks).
- SHIFT=4, OUT_W=20, P=2^30 → out_data_o=524287, sat=1; P=-2^30 → -524288, sat=1.
- out_ready_i held 0, three frames of dump_len=2 → two words buffered, FSM holds CAPTURE with in_ready_o=0 and acc_clear_o=0. Raising out_ready_i drains the words in order, and the third word is pushed on the first pop cycle.
- dump_len_i=0 → every accepted sample produces one output word with a 2-cycle gap. Changing dump_len_i from 3 to 5 mid-frame leaves the current frame at 3.
- reset asserted after 2 of 4 samples, then a full frame of 1, 1, 1, 1 with SHIFT=1 → outputs idle during reset; the first word after reset equals (4+1)>>>1 = 2.
